// File: rtl/digdug_bus_pkg.sv
// ---------------------------------------------------------------------------
// digdug_bus_pkg
// Shared constants and helpers for the target end of the time-multiplexed CPU
// device bus: default address windows, control latch indices, the NMI pulse
// length and the address decode used by the responder.
// ---------------------------------------------------------------------------
package digdug_bus_pkg;

  // Default address windows
  localparam int          RAM_AW_DEF   = 13;
  localparam logic [15:0] RAM_BASE_DEF = 16'h8000;
  localparam logic [15:0] LAT_BASE_DEF = 16'h6820;

  // Control latch indices inside the 0x6820-0x6827 block
  localparam int LAT_IRQ0    = 0;
  localparam int LAT_IRQ1    = 1;
  localparam int LAT_NMI2INH = 2;
  localparam int LAT_SUBRUN  = 3;

  // NMI pulse length in MCLK cycles and the counter width that covers it
  localparam int NMI_LEN = 64;
  localparam int NMI_CW  = $clog2(NMI_LEN);

  // Which owner answers a given bus address
  typedef enum logic [1:0] {
    TGT_EXT = 2'd0,
    TGT_RAM = 2'd1,
    TGT_LAT = 2'd2
  } target_e;

  // Work RAM takes priority so that an overlapping latch window can never
  // shadow RAM if the bases are ever moved.
  function automatic target_e decodeTarget(input logic [15:0] ad,
                                           input logic [15:0] ramBase,
                                           input logic [15:0] latBase,
                                           input int          ramAw);
    if ((ad >> ramAw) == (ramBase >> ramAw)) return TGT_RAM;
    if (ad[15:3] == latBase[15:3])           return TGT_LAT;
    return TGT_EXT;
  endfunction

endpackage

// File: rtl/digdug_irqlatch.sv
// ---------------------------------------------------------------------------
// digdug_irqlatch
// The eight one-bit control latches plus everything driven by them: VBLK
// rising-edge detect, the two CPU IRQ pending bits, the CPU2 NMI pulse timer
// and the sub-CPU reset.
//
// Ports
//   mclk_i     system clock
//   reset_i    asynchronous active-high reset
//   vblk_i     vertical blank level, MCLK synchronous
//   latWe_i    one-cycle latch write strobe (already commit-qualified)
//   latIdx_i   latch index being written
//   latBit_i   value written to the latch
//   latch_o    current latch contents (for read-back)
//   pend_o     IRQ pending bits, [0]=CPU0, [1]=CPU1
//   nmi2_o     CPU2 NMI request level
//   subrst_o   sub-CPU reset, 1 = held in reset
// ---------------------------------------------------------------------------
module digdug_irqlatch
  import digdug_bus_pkg::*;
(
  input  logic       mclk_i,
  input  logic       reset_i,
  input  logic       vblk_i,
  input  logic       latWe_i,
  input  logic [2:0] latIdx_i,
  input  logic       latBit_i,
  output logic [7:0] latch_o,
  output logic [1:0] pend_o,
  output logic       nmi2_o,
  output logic       subrst_o
);

  logic [7:0]        latch_q, latch_d;
  logic              vblk_q;
  logic [1:0]        pend_q, pend_d;
  logic              nmiActive_q, nmiActive_d;
  logic [NMI_CW-1:0] nmiCnt_q, nmiCnt_d;
  logic              vblkRise;

  assign vblkRise = vblk_i & ~vblk_q;

  // Latch file: a commit overwrites exactly one bit.
  always_comb begin
    latch_d = latch_q;
    if (latWe_i) latch_d[latIdx_i] = latBit_i;
  end

  // IRQ pending bits. A VBLK edge arms a bit only when its enable was already
  // set; writing 0 to the enable is the acknowledge, and it is evaluated last
  // so that an ack landing on the same cycle as an edge wins.
  always_comb begin
    pend_d = pend_q;
    if (vblkRise && latch_q[LAT_IRQ0]) pend_d[0] = 1'b1;
    if (vblkRise && latch_q[LAT_IRQ1]) pend_d[1] = 1'b1;
    if (latWe_i && !latBit_i && latIdx_i == 3'(LAT_IRQ0)) pend_d[0] = 1'b0;
    if (latWe_i && !latBit_i && latIdx_i == 3'(LAT_IRQ1)) pend_d[1] = 1'b0;
  end

  // NMI timer. The active flag plus a count loaded with NMI_LEN-1 gives a
  // pulse of exactly NMI_LEN cycles. The inhibit is taken from the next latch
  // value so that writing it drops NMI2 on the very next cycle.
  always_comb begin
    nmiActive_d = nmiActive_q;
    nmiCnt_d    = nmiCnt_q;
    if (latch_d[LAT_NMI2INH]) begin
      nmiActive_d = 1'b0;
      nmiCnt_d    = '0;
    end else if (vblkRise) begin
      nmiActive_d = 1'b1;
      nmiCnt_d    = NMI_CW'(NMI_LEN - 1);
    end else if (nmiActive_q) begin
      if (nmiCnt_q == '0) nmiActive_d = 1'b0;
      else                nmiCnt_d    = nmiCnt_q - 1'b1;
    end
  end

  // State registers; all latches clear on reset, which also holds the
  // sub-CPUs in reset until software sets the run latch.
  always_ff @(posedge mclk_i or posedge reset_i) begin
    if (reset_i) begin
      latch_q     <= '0;
      vblk_q      <= 1'b0;
      pend_q      <= '0;
      nmiActive_q <= 1'b0;
      nmiCnt_q    <= '0;
    end else begin
      latch_q     <= latch_d;
      vblk_q      <= vblk_i;
      pend_q      <= pend_d;
      nmiActive_q <= nmiActive_d;
      nmiCnt_q    <= nmiCnt_d;
    end
  end

  assign latch_o  = latch_q;
  assign pend_o   = pend_q;
  assign nmi2_o   = nmiActive_q;
  assign subrst_o = ~latch_q[LAT_SUBRUN];

endmodule

// File: rtl/digdug_dev_responder.sv
// ---------------------------------------------------------------------------
// digdug_dev_responder
// Target end of the time-multiplexed CPU device bus. Decodes the muxed
// request from the 3-CPU arbiter, owns the shared work RAM and the control
// latches, and forwards every other address to the external port. Read data
// is returned one MCLK after the request, well inside one arbiter slot.
//
// Ports
//   mclk_i     48 MHz system clock
//   reset_i    asynchronous active-high reset
//   devAd_i    bus address         devRd_i / devWr_i  read / write request
//   devDi_i    write data          devDv_o / devDo_o  registered read valid/data
//   vblk_i     vertical blank      irqs_o             [0]=CPU0 [1]=CPU1 [2]=0
//   nmi2_o     CPU2 NMI level      subrst_o           CPU1/CPU2 reset
//   extAd_o / extDi_o  address and write data passed through
//   extRd_o    read request for external addresses
//   extWe_o    one-cycle write commit strobe for external addresses
//   extDv_i / extDo_i  external read data, valid in the request cycle
// ---------------------------------------------------------------------------
module digdug_dev_responder
  import digdug_bus_pkg::*;
#(
  parameter int          RAM_AW   = RAM_AW_DEF,
  parameter logic [15:0] RAM_BASE = RAM_BASE_DEF,
  parameter logic [15:0] LAT_BASE = LAT_BASE_DEF
) (
  input  logic        mclk_i,
  input  logic        reset_i,
  input  logic [15:0] devAd_i,
  input  logic        devRd_i,
  input  logic        devWr_i,
  input  logic [7:0]  devDi_i,
  output logic        devDv_o,
  output logic [7:0]  devDo_o,
  input  logic        vblk_i,
  output logic [2:0]  irqs_o,
  output logic        nmi2_o,
  output logic        subrst_o,
  output logic [15:0] extAd_o,
  output logic        extRd_o,
  output logic        extWe_o,
  output logic [7:0]  extDi_o,
  input  logic        extDv_i,
  input  logic [7:0]  extDo_i
);

  target_e           target;
  logic              ramHit, latHit, extHit;
  logic              wr_q;
  logic [15:0]       ad_q;
  logic [7:0]        di_q;
  logic              commit;
  logic [RAM_AW-1:0] ramIdx;
  logic [7:0]        mem [2**RAM_AW];
  logic [7:0]        latches;
  logic [1:0]        pend;
  logic              rdDv;
  logic [7:0]        rdData;
  logic              devDv_q;
  logic [7:0]        devDo_q;

  assign target = decodeTarget(devAd_i, RAM_BASE, LAT_BASE, RAM_AW);
  assign ramHit = (target == TGT_RAM);
  assign latHit = (target == TGT_LAT);
  assign extHit = (target == TGT_EXT);
  assign ramIdx = devAd_i[RAM_AW-1:0];

  // The arbiter holds a write on the bus for a whole slot, so a write is only
  // acted on when it first appears or when its address or data changes.
  assign commit = devWr_i & (~wr_q | (devAd_i != ad_q) | (devDi_i != di_q));

  // External port: address/data pass straight through, strobes are gated so
  // that locally owned addresses never reach the video/sound/IO side.
  assign extAd_o = devAd_i;
  assign extDi_o = devDi_i;
  assign extRd_o = devRd_i & extHit;
  assign extWe_o = commit & extHit;

  digdug_irqlatch uIrqLatch (
    .mclk_i   (mclk_i),
    .reset_i  (reset_i),
    .vblk_i   (vblk_i),
    .latWe_i  (commit & latHit),
    .latIdx_i (devAd_i[2:0]),
    .latBit_i (devDi_i[0]),
    .latch_o  (latches),
    .pend_o   (pend),
    .nmi2_o   (nmi2_o),
    .subrst_o (subrst_o)
  );

  assign irqs_o = {1'b0, pend};

  // Work RAM write port. Contents are deliberately not reset.
  always_ff @(posedge mclk_i) begin
    if (commit && ramHit) mem[ramIdx] <= devDi_i;
  end

  // Read source select. The RAM is sampled before this cycle's write lands,
  // so a read and write to the same address return the old byte.
  always_comb begin
    rdDv   = extDv_i;
    rdData = extDo_i;
    case (target)
      TGT_RAM: begin
        rdDv   = 1'b1;
        rdData = mem[ramIdx];
      end
      TGT_LAT: begin
        rdDv   = 1'b1;
        rdData = {7'b0, latches[devAd_i[2:0]]};
      end
      default: begin
        rdDv   = extDv_i;
        rdData = extDo_i;
      end
    endcase
  end

  // Previous-cycle write copies for commit detection, and the registered read
  // return. Read data holds between reads; reset drops any read in flight.
  always_ff @(posedge mclk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q    <= 1'b0;
      ad_q    <= '0;
      di_q    <= '0;
      devDv_q <= 1'b0;
      devDo_q <= '0;
    end else begin
      wr_q    <= devWr_i;
      ad_q    <= devAd_i;
      di_q    <= devDi_i;
      devDv_q <= devRd_i & rdDv;
      if (devRd_i) devDo_q <= rdData;
    end
  end

  assign devDv_o = devDv_q;
  assign devDo_o = devDo_q;

endmodule

// File: tb/tb_digdug_dev_responder.sv
// ---------------------------------------------------------------------------
// tb_digdug_dev_responder
// Self-checking bench for the device bus responder: a directed vector table,
// hand-written IRQ/NMI/reset sequences and a randomized run, all compared
// against a behavioural model of the bus target kept in this file.
// ---------------------------------------------------------------------------
module tb_digdug_dev_responder;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] devAd = '0;
  logic        devRd = 1'b0;
  logic        devWr = 1'b0;
  logic [7:0]  devDi = '0;
  logic        devDv;
  logic [7:0]  devDo;
  logic        vblk = 1'b0;
  logic [2:0]  irqs;
  logic        nmi2;
  logic        subrst;
  logic [15:0] extAd;
  logic        extRd;
  logic        extWe;
  logic [7:0]  extDi;
  logic        extDv = 1'b0;
  logic [7:0]  extDo = '0;

  int testsRun = 0;
  int testsFailed = 0;

  digdug_dev_responder dut (
    .mclk_i   (mclk),
    .reset_i  (reset),
    .devAd_i  (devAd),
    .devRd_i  (devRd),
    .devWr_i  (devWr),
    .devDi_i  (devDi),
    .devDv_o  (devDv),
    .devDo_o  (devDo),
    .vblk_i   (vblk),
    .irqs_o   (irqs),
    .nmi2_o   (nmi2),
    .subrst_o (subrst),
    .extAd_o  (extAd),
    .extRd_o  (extRd),
    .extWe_o  (extWe),
    .extDi_o  (extDi),
    .extDv_i  (extDv),
    .extDo_i  (extDo)
  );

  // 48 MHz nominal; the absolute period does not matter to the design.
  always #5 mclk = ~mclk;

  // Safety net in case the run never reaches its summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- behavioural reference model ----------------
  logic [7:0]  mRam [8192];
  bit          mKnown [8192];
  bit   [7:0]  mLat;
  bit   [1:0]  mPend;
  int          mNmiLeft;
  bit          mPrevWr;
  logic [15:0] mPrevAd;
  logic [7:0]  mPrevDi;
  bit          mPrevVblk;
  bit          eDv;
  logic [7:0]  eDo;
  bit          eDoKnown;
  bit          eExtRd;
  bit          eExtWe;
  bit          lastExtWe;

  task automatic modelReset();
    mLat      = '0;
    mPend     = '0;
    mNmiLeft  = 0;
    mPrevWr   = 1'b0;
    mPrevAd   = '0;
    mPrevDi   = '0;
    mPrevVblk = 1'b0;
    eDv       = 1'b0;
    eDo       = '0;
    eDoKnown  = 1'b1;
  endtask

  // One bus cycle of the target as described by its rules: address windows
  // by range, writes acted on once, reads return pre-write contents.
  task automatic modelStep(input bit rd, input bit wr, input logic [15:0] ad,
                           input logic [7:0] di, input bit vb,
                           input bit xDv, input logic [7:0] xDo);
    bit isRam, isLat, commit, rise;
    int idx;
    isRam  = (ad >= 16'h8000) && (ad <= 16'h9FFF);
    isLat  = (ad >= 16'h6820) && (ad <= 16'h6827);
    commit = wr && (!mPrevWr || ad != mPrevAd || di != mPrevDi);
    eExtRd = rd && !isRam && !isLat;
    eExtWe = commit && !isRam && !isLat;
    if (rd) begin
      if (isRam) begin
        idx = int'(ad) - 'h8000;
        eDv = 1'b1; eDo = mRam[idx]; eDoKnown = mKnown[idx];
      end else if (isLat) begin
        idx = int'(ad) - 'h6820;
        eDv = 1'b1; eDo = {7'b0, mLat[idx]}; eDoKnown = 1'b1;
      end else begin
        eDv = xDv; eDo = xDo; eDoKnown = 1'b1;
      end
    end else begin
      eDv = 1'b0;
    end
    rise = vb && !mPrevVblk;
    for (int i = 0; i < 2; i++) if (rise && mLat[i]) mPend[i] = 1'b1;
    if (commit && isLat) begin
      idx = int'(ad) - 'h6820;
      mLat[idx] = di[0];
      if (idx < 2 && !di[0]) mPend[idx] = 1'b0;
    end
    if (commit && isRam) begin
      idx = int'(ad) - 'h8000;
      mRam[idx] = di; mKnown[idx] = 1'b1;
    end
    if (mLat[2])          mNmiLeft = 0;
    else if (rise)        mNmiLeft = 64;
    else if (mNmiLeft > 0) mNmiLeft--;
    mPrevWr = wr; mPrevAd = ad; mPrevDi = di; mPrevVblk = vb;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one bus cycle (called just after a rising edge), step the model
  // and, when asked, compare both the combinational and registered outputs.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [15:0] ad,
                               input logic [7:0] di, input bit vb,
                               input bit xDv, input logic [7:0] xDo,
                               input bit useModel);
    devRd = rd; devWr = wr; devAd = ad; devDi = di; vblk = vb;
    extDv = xDv; extDo = xDo;
    #1;
    modelStep(rd, wr, ad, di, vb, xDv, xDo);
    lastExtWe = extWe;
    if (useModel) begin
      checkOutput("extRd", extRd, eExtRd);
      checkOutput("extWe", extWe, eExtWe);
      checkOutput("extAd", extAd, ad);
      checkOutput("extDi", extDi, di);
    end
    @(posedge mclk);
    #1;
    if (useModel) begin
      checkOutput("devDv", devDv, eDv);
      if (eDoKnown) checkOutput("devDo", devDo, eDo);
      checkOutput("irqs", irqs, {1'b0, mPend});
      checkOutput("nmi2", nmi2, mNmiLeft > 0);
      checkOutput("subrst", subrst, !mLat[3]);
    end
  endtask

  task automatic idleCycle(input bit vb);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, vb, 1'b0, 8'h00, 1'b1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] ad;
    logic [7:0]  di;
    bit          xDv;
    logic [7:0]  xDo;
    bit          expWe;
    bit          expDv;
    logic [7:0]  expDo;
    bit          expSubrst;
  } vec_t;

  function automatic vec_t mkVec(input bit rd, input bit wr, input logic [15:0] ad,
                                 input logic [7:0] di, input bit xDv,
                                 input logic [7:0] xDo, input bit expWe,
                                 input bit expDv, input logic [7:0] expDo,
                                 input bit expSubrst);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ad = ad; v.di = di; v.xDv = xDv; v.xDo = xDo;
    v.expWe = expWe; v.expDv = expDv; v.expDo = expDo; v.expSubrst = expSubrst;
    return v;
  endfunction

  vec_t vecs [20];

  initial begin
    int nmiHigh;
    bit highBefore;
    bit rd, wr, vb, xDv;
    logic [15:0] ad;
    logic [7:0]  di, xDo;

    for (int i = 0; i < 8192; i++) mKnown[i] = 1'b0;

    //                rd wr ad        di     xDv xDo    we dv do     subrst
    vecs[0]  = mkVec(0, 1, 16'h8123, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 1);
    vecs[1]  = mkVec(0, 1, 16'h8123, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 1);
    vecs[2]  = mkVec(0, 1, 16'h8123, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 1);
    vecs[3]  = mkVec(0, 1, 16'h8123, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 1);
    vecs[4]  = mkVec(1, 0, 16'h8123, 8'h00, 0, 8'h00, 0, 1, 8'hA5, 1);
    vecs[5]  = mkVec(0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 8'hA5, 1);
    vecs[6]  = mkVec(0, 1, 16'h6823, 8'h01, 0, 8'h00, 0, 0, 8'hA5, 0);
    vecs[7]  = mkVec(1, 0, 16'h6823, 8'h00, 0, 8'h00, 0, 1, 8'h01, 0);
    vecs[8]  = mkVec(1, 0, 16'h6827, 8'h00, 0, 8'h00, 0, 1, 8'h00, 0);
    vecs[9]  = mkVec(1, 0, 16'h7000, 8'h00, 1, 8'h3C, 0, 1, 8'h3C, 0);
    vecs[10] = mkVec(1, 0, 16'h7000, 8'h00, 0, 8'h55, 0, 0, 8'h55, 0);
    vecs[11] = mkVec(0, 1, 16'hA003, 8'h77, 0, 8'h00, 1, 0, 8'h55, 0);
    vecs[12] = mkVec(0, 1, 16'hA003, 8'h77, 0, 8'h00, 0, 0, 8'h55, 0);
    vecs[13] = mkVec(0, 1, 16'hA003, 8'h77, 0, 8'h00, 0, 0, 8'h55, 0);
    vecs[14] = mkVec(0, 1, 16'hA003, 8'h77, 0, 8'h00, 0, 0, 8'h55, 0);
    vecs[15] = mkVec(0, 1, 16'hA003, 8'h78, 0, 8'h00, 1, 0, 8'h55, 0);
    vecs[16] = mkVec(0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 8'h55, 0);
    vecs[17] = mkVec(1, 1, 16'h8123, 8'h5A, 0, 8'h00, 0, 1, 8'hA5, 0);
    vecs[18] = mkVec(1, 0, 16'h8123, 8'h00, 0, 8'h00, 0, 1, 8'h5A, 0);
    vecs[19] = mkVec(0, 1, 16'h6823, 8'h00, 0, 8'h00, 0, 0, 8'h5A, 1);

    // Reset state
    repeat (3) @(posedge mclk);
    #1;
    reset = 1'b0;
    modelReset();
    checkOutput("rstDevDv", devDv, 1'b0);
    checkOutput("rstDevDo", devDo, 8'h00);
    checkOutput("rstIrqs", irqs, 3'b000);
    checkOutput("rstNmi2", nmi2, 1'b0);
    checkOutput("rstSubrst", subrst, 1'b1);

    // Directed table: RAM, latch, external reads/writes and commit detection
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].ad, vecs[i].di, 1'b0,
                    vecs[i].xDv, vecs[i].xDo, 1'b0);
      checkOutput($sformatf("vec%0d.extWe", i), lastExtWe, vecs[i].expWe);
      checkOutput($sformatf("vec%0d.devDv", i), devDv, vecs[i].expDv);
      checkOutput($sformatf("vec%0d.devDo", i), devDo, vecs[i].expDo);
      checkOutput($sformatf("vec%0d.subrst", i), subrst, vecs[i].expSubrst);
    end

    // IRQ: enable CPU0 only, raise VBLK, ack, then edge and ack together
    applyStimulus(1'b0, 1'b1, 16'h6820, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h6821, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    idleCycle(1'b0);
    idleCycle(1'b1);
    checkOutput("irq0Set", irqs[0], 1'b1);
    checkOutput("irq1StaysLow", irqs[1], 1'b0);
    idleCycle(1'b0);
    checkOutput("irq0Held", irqs[0], 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h6820, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("irq0Ack", irqs[0], 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h6820, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    idleCycle(1'b0);
    applyStimulus(1'b0, 1'b1, 16'h6820, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("irqAckWinsOverEdge", irqs[0], 1'b0);
    idleCycle(1'b0);
    repeat (70) idleCycle(1'b0);
    checkOutput("nmiQuiet", nmi2, 1'b0);

    // NMI: single edge gives exactly 64 high cycles
    nmiHigh = 0;
    for (int i = 0; i < 100; i++) begin
      idleCycle(i < 5);
      if (nmi2) nmiHigh++;
    end
    checkOutput("nmiPulseLen", nmiHigh, 64);

    // NMI: second edge at cycle 30 reloads, 64 cycles from the reload
    nmiHigh = 0;
    highBefore = 1'b0;
    for (int i = 0; i < 130; i++) begin
      idleCycle(i == 0 || i == 30);
      if (i == 29) highBefore = nmi2;
      if (i >= 30 && nmi2) nmiHigh++;
    end
    checkOutput("nmiHighBeforeReload", highBefore, 1'b1);
    checkOutput("nmiReloadLen", nmiHigh, 64);

    // NMI: inhibit written at cycle 10 drops NMI2 on the next cycle
    for (int i = 0; i < 20; i++) begin
      if (i == 10)
        applyStimulus(1'b0, 1'b1, 16'h6822, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
      else
        idleCycle(i < 3);
      if (i == 9)  checkOutput("nmiBeforeInhibit", nmi2, 1'b1);
      if (i == 10) checkOutput("nmiInhibit", nmi2, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 16'h6822, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    idleCycle(1'b0);

    // Reset during a pending read: no data valid, RAM keeps its contents
    devRd = 1'b1; devWr = 1'b0; devAd = 16'h8123; vblk = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge mclk);
    #1;
    checkOutput("rstMidReadDv", devDv, 1'b0);
    checkOutput("rstMidReadDo", devDo, 8'h00);
    checkOutput("rstMidReadSubrst", subrst, 1'b1);
    devRd = 1'b0;
    #2;
    reset = 1'b0;
    modelReset();
    idleCycle(1'b0);
    applyStimulus(1'b1, 1'b0, 16'h8123, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("ramSurvivesReset", devDo, 8'h5A);

    // Randomized traffic against the model
    rd = 1'b0; wr = 1'b0; vb = 1'b0; ad = '0; di = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        wr = ($urandom_range(0, 2) != 0);
        di = 8'($urandom);
        case ($urandom_range(0, 3))
          0:       ad = 16'h8000 + 16'($urandom_range(0, 15));
          1:       ad = 16'h6820 + 16'($urandom_range(0, 7));
          2:       ad = 16'h7000 + 16'($urandom_range(0, 3));
          default: ad = 16'($urandom);
        endcase
      end
      rd  = ($urandom_range(0, 1) == 1);
      xDv = ($urandom_range(0, 1) == 1);
      xDo = 8'($urandom);
      if ($urandom_range(0, 19) == 0) vb = ~vb;
      applyStimulus(rd, wr, ad, di, vb, xDv, xDo, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
